// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs (package)
//  Description : Shared CPU front-end definitions: reset vector, bus size
//                code, fetch FSM states and the fetch-entry record that
//                travels from IF into the IF/ID pipeline register.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_defs;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc0_0000;
   localparam logic [1:0]  SIZE_WORD        = 2'b10;

   typedef enum logic [0:0] {
      S_REQ  = 1'b0,
      S_WAIT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buf
//  Description : One-entry holding register for a returned instruction that
//                could not enter the output slot. Flush beats load; load
//                beats unload so a simultaneous swap keeps the new entry.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_skid_buf
   import cpu_defs::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         load,
   input  fetch_entry_t load_entry,
   input  logic         unload,
   output logic         valid,
   output fetch_entry_t entry
);

   logic         valid_d, valid_q;
   fetch_entry_t entry_d, entry_q;

   // Next-state for the holding register.
   always_comb begin
      valid_d = valid_q;
      entry_d = entry_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         entry_d = load_entry;
      end else if (unload) begin
         valid_d = 1'b0;
      end
   end

   // Holding register state.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         entry_q <= '0;
      end else begin
         valid_q <= valid_d;
         entry_q <= entry_d;
      end
   end

   assign valid = valid_q;
   assign entry = entry_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_stage
//  Description : Instruction-fetch stage. Drives the PC onto an SRAM-like
//                read bus with one read outstanding, hands pc/inst pairs to
//                ID over a valid/allowin handshake, honours branch and
//                exception redirects (cancelling in-flight reads) and uses
//                a one-entry skid buffer so ID stalls never drop data.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_stage
   import cpu_defs::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_flush,
   input  logic [31:0] exc_target,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        inst_sram_req,
   output logic        inst_sram_wr,
   output logic [1:0]  inst_sram_size,
   output logic [31:0] inst_sram_addr,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata,
   input  logic        id_allowin,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_adel
);

   fetch_state_e state_d, state_q;
   logic [31:0]  pc_d, pc_q;
   logic [31:0]  req_pc_d, req_pc_q;     // address of the read in flight
   logic         cancel_d, cancel_q;     // in-flight read must be dropped
   logic         adel_done_d, adel_done_q;
   logic         out_valid_d, out_valid_q;
   fetch_entry_t out_d, out_q;

   logic         skid_valid, skid_load, skid_unload, skid_flush;
   fetch_entry_t skid_entry, w_new_entry;

   logic         w_redirect, w_pc_aligned, w_accept, w_resp, w_deliver;
   logic         w_out_free, w_adel_load;
   logic [31:0]  w_redirect_pc;

   // Exception redirect has priority over a branch in the same cycle.
   assign w_redirect    = exc_flush | br_taken;
   assign w_redirect_pc = exc_flush ? exc_target : br_target;
   assign w_pc_aligned  = (pc_q[1:0] == 2'b00);

   assign inst_sram_req  = ~reset & (state_q == S_REQ) & w_pc_aligned & ~skid_valid;
   assign inst_sram_wr   = 1'b0;
   assign inst_sram_size = SIZE_WORD;
   assign inst_sram_addr = pc_q;

   assign w_accept   = inst_sram_req & inst_sram_addr_ok;
   assign w_resp     = (state_q == S_WAIT) & inst_sram_data_ok;
   assign w_deliver  = w_resp & ~cancel_q & ~w_redirect;
   assign w_out_free = ~out_valid_q | id_allowin;
   // A misaligned PC produces exactly one AdEL entry, then fetch idles.
   assign w_adel_load = (state_q == S_REQ) & ~w_pc_aligned & ~adel_done_q &
                        w_out_free & ~skid_valid & ~w_redirect;

   assign w_new_entry.pc   = req_pc_q;
   assign w_new_entry.inst = inst_sram_rdata;
   assign w_new_entry.adel = 1'b0;

   // Fetch FSM next-state, PC sequencing and cancel tracking.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      cancel_d    = cancel_q;
      adel_done_d = adel_done_q;
      case (state_q)
         S_REQ: begin
            if (w_accept) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + 32'd4;
               state_d  = S_WAIT;
            end
            if (w_adel_load) begin
               adel_done_d = 1'b1;
            end
         end
         S_WAIT: begin
            if (inst_sram_data_ok) begin
               state_d  = S_REQ;
               cancel_d = 1'b0;
            end
         end
         default: state_d = S_REQ;
      endcase
      if (w_redirect) begin
         pc_d        = w_redirect_pc;
         adel_done_d = 1'b0;
         // A read that is (or becomes) outstanding belongs to the old path.
         if (((state_q == S_REQ) && w_accept) ||
             ((state_q == S_WAIT) && !inst_sram_data_ok)) begin
            cancel_d = 1'b1;
         end
      end
   end

   // Output slot and skid-buffer steering.
   always_comb begin
      out_valid_d = out_valid_q;
      out_d       = out_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_flush  = w_redirect;
      if (w_redirect) begin
         out_valid_d = 1'b0;
      end else if (w_out_free) begin
         if (skid_valid) begin
            out_valid_d = 1'b1;
            out_d       = skid_entry;
            skid_unload = 1'b1;
            skid_load   = w_deliver;
         end else if (w_deliver) begin
            out_valid_d = 1'b1;
            out_d       = w_new_entry;
         end else if (w_adel_load) begin
            out_valid_d = 1'b1;
            out_d.pc    = pc_q;
            out_d.inst  = 32'h0;
            out_d.adel  = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (w_deliver) begin
         skid_load = 1'b1;
      end
   end

   // Stage state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         req_pc_q    <= 32'h0;
         cancel_q    <= 1'b0;
         adel_done_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_q       <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         cancel_q    <= cancel_d;
         adel_done_q <= adel_done_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   fetch_skid_buf u_skid (
      .clk        (clk),
      .reset      (reset),
      .flush      (skid_flush),
      .load       (skid_load),
      .load_entry (w_new_entry),
      .unload     (skid_unload),
      .valid      (skid_valid),
      .entry      (skid_entry)
   );

   assign if_valid = out_valid_q;
   assign if_pc    = out_q.pc;
   assign if_inst  = out_q.inst;
   assign if_adel  = out_q.adel;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_stage
//  Description : Self-checking bench for if_fetch_stage: SRAM-like bus
//                responder, instruction-stream reference model, vector
//                table, directed corner sequences and random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch_stage;

   localparam logic [31:0] RST_PC = 32'hbfc0_0000;

   logic        clk = 1'b0;
   logic        reset, exc_flush, br_taken, id_allowin;
   logic [31:0] exc_target, br_target;
   logic        inst_sram_req, inst_sram_wr;
   logic [1:0]  inst_sram_size;
   logic [31:0] inst_sram_addr, inst_sram_rdata;
   logic        inst_sram_addr_ok, inst_sram_data_ok;
   logic        if_valid, if_adel;
   logic [31:0] if_pc, if_inst;

   always #5 clk = ~clk;

   if_fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk               (clk),
      .reset             (reset),
      .exc_flush         (exc_flush),
      .exc_target        (exc_target),
      .br_taken          (br_taken),
      .br_target         (br_target),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .id_allowin        (id_allowin),
      .if_valid          (if_valid),
      .if_pc             (if_pc),
      .if_inst           (if_inst),
      .if_adel           (if_adel)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // bus responder knobs and state
   int          ok_pct = 100;
   int          lat_lo = 0;
   int          lat_hi = 0;
   bit          poison = 1'b0;
   bit          pend = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   int          cnt = 0;
   bit          req_s = 1'b0;
   logic [31:0] addr_s = 32'h0;

   // reference model: the next PC the program-order stream must deliver
   logic [31:0] exp_pc = RST_PC;
   bit          dead = 1'b0;
   bit          hold_chk = 1'b0;
   bit          flush_chk = 1'b0;
   logic [31:0] held_pc, held_inst;
   logic        held_adel;
   int          n_hs = 0;

   typedef struct {
      bit          rst;
      bit          allow;
      bit          exp_req;
      logic [31:0] exp_addr;
      bit          exp_valid;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t vt [19];

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9e37_79b1) ^ 32'h5bd1_e995;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at negedge after inputs are set: bus response, model checks.
   task automatic drive();
      bit hs, redir;
      #1;
      inst_sram_addr_ok = inst_sram_req && (int'($urandom_range(99)) < ok_pct);
      inst_sram_data_ok = pend && (cnt == 0) && !reset;
      inst_sram_rdata   = inst_sram_data_ok ? (poison ? 32'hdeadbeef : mem(pend_addr)) : $urandom;
      #1;
      req_s  = inst_sram_req;
      addr_s = inst_sram_addr;
      if (reset) chk("req_in_reset", 32'(inst_sram_req), 32'd0);
      if (inst_sram_req) begin
         chk("one_outstanding", 32'(pend), 32'd0);
         chk("addr_align", 32'(inst_sram_addr[1:0]), 32'd0);
         chk("size_word", 32'(inst_sram_size), 32'd2);
         chk("wr_zero", 32'(inst_sram_wr), 32'd0);
      end
      if (hold_chk) begin
         chk("hold_valid", 32'(if_valid), 32'd1);
         chk("hold_pc", if_pc, held_pc);
         chk("hold_inst", if_inst, held_inst);
         chk("hold_adel", 32'(if_adel), 32'(held_adel));
      end
      hs = if_valid && id_allowin && !reset;
      if (hs) begin
         n_hs++;
         if (dead) begin
            chk("adel_stall_extra", 32'(if_valid), 32'd0);
         end else if (exp_pc[1:0] != 2'b00) begin
            chk("adel_pc", if_pc, exp_pc);
            chk("adel_inst", if_inst, 32'd0);
            chk("adel_flag", 32'(if_adel), 32'd1);
            dead = 1'b1;
         end else begin
            chk("seq_pc", if_pc, exp_pc);
            chk("seq_inst", if_inst, mem(exp_pc));
            chk("seq_adel", 32'(if_adel), 32'd0);
            exp_pc = exp_pc + 32'd4;
         end
      end
      redir     = (exc_flush || br_taken) && !reset;
      hold_chk  = if_valid && !id_allowin && !redir && !reset;
      held_pc   = if_pc;
      held_inst = if_inst;
      held_adel = if_adel;
      flush_chk = redir || reset;
      if (reset) begin
         exp_pc = RST_PC;
         dead   = 1'b0;
      end else if (redir) begin
         exp_pc = exc_flush ? exc_target : br_target;
         dead   = 1'b0;
      end
   endtask

   // Active edge, bus bookkeeping, post-edge checks, back to negedge.
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         pend = 1'b0;
         cnt  = 0;
      end else begin
         if (inst_sram_data_ok) pend = 1'b0;
         if (req_s && inst_sram_addr_ok) begin
            pend      = 1'b1;
            pend_addr = addr_s;
            cnt       = int'($urandom_range(lat_hi, lat_lo));
         end else if (pend && cnt > 0) begin
            cnt--;
         end
      end
      #1;
      if (flush_chk) chk("flush_valid", 32'(if_valid), 32'd0);
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      br_taken = 1'b0;
      exc_flush = 1'b0;
      repeat (n) begin
         drive();
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bit got;
      reset = 1'b1; exc_flush = 1'b0; br_taken = 1'b0; id_allowin = 1'b1;
      exc_target = 32'h0; br_target = 32'h0;
      inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;

      //            rst allow req  addr           valid pc
      vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      vt[1]  = '{1'b0, 1'b1, 1'b1, 32'hbfc00000, 1'b0, 32'h0};
      vt[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      vt[3]  = '{1'b0, 1'b1, 1'b1, 32'hbfc00004, 1'b1, 32'hbfc00000};
      vt[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      vt[5]  = '{1'b0, 1'b1, 1'b1, 32'hbfc00008, 1'b1, 32'hbfc00004};
      vt[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      vt[7]  = '{1'b0, 1'b1, 1'b1, 32'hbfc0000c, 1'b1, 32'hbfc00008};
      vt[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      vt[9]  = '{1'b0, 1'b0, 1'b1, 32'hbfc00000, 1'b0, 32'h0};
      vt[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
      vt[11] = '{1'b0, 1'b0, 1'b1, 32'hbfc00004, 1'b1, 32'hbfc00000};
      vt[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hbfc00000};
      vt[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hbfc00000};
      vt[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hbfc00000};
      vt[15] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'hbfc00000};
      vt[16] = '{1'b0, 1'b1, 1'b1, 32'hbfc00008, 1'b1, 32'hbfc00004};
      vt[17] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      vt[18] = '{1'b0, 1'b1, 1'b1, 32'hbfc0000c, 1'b1, 32'hbfc00008};

      @(negedge clk);
      do_reset(2);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_inst", if_inst, 32'd0);
      chk("rst_adel", 32'(if_adel), 32'd0);

      // zero-wait streaming and ID stall with skid, from the vector table
      for (int i = 0; i < 19; i++) begin
         reset = vt[i].rst;
         id_allowin = vt[i].allow;
         drive();
         chk($sformatf("vec%0d_req", i), 32'(inst_sram_req), 32'(vt[i].exp_req));
         if (vt[i].exp_req) chk($sformatf("vec%0d_addr", i), inst_sram_addr, vt[i].exp_addr);
         chk($sformatf("vec%0d_valid", i), 32'(if_valid), 32'(vt[i].exp_valid));
         if (vt[i].exp_valid) begin
            chk($sformatf("vec%0d_pc", i), if_pc, vt[i].exp_pc);
            chk($sformatf("vec%0d_inst", i), if_inst, mem(vt[i].exp_pc));
         end
         tick();
      end
      reset = 1'b0;

      // branch while waiting on a slow read: the returned word is dropped
      do_reset(1);
      id_allowin = 1'b1; lat_lo = 3; lat_hi = 3; poison = 1'b1;
      drive();
      chk("br_req0", 32'(inst_sram_req), 32'd1);
      chk("br_addr0", inst_sram_addr, RST_PC);
      tick();
      br_taken = 1'b1; br_target = 32'h8000_1000;
      drive();
      chk("br_wait_noreq", 32'(inst_sram_req), 32'd0);
      tick();
      br_taken = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         drive();
         chk("br_no_stale", 32'(if_valid), 32'd0);
         if (inst_sram_req) begin
            got = 1'b1;
            chk("br_new_addr", inst_sram_addr, 32'h8000_1000);
            lat_lo = 0; lat_hi = 0; poison = 1'b0;
         end
         tick();
      end
      chk("br_req_seen", 32'(got), 32'd1);
      drive(); tick();
      drive();
      chk("br_valid", 32'(if_valid), 32'd1);
      chk("br_pc", if_pc, 32'h8000_1000);
      chk("br_inst", if_inst, mem(32'h8000_1000));
      tick();

      // branch and exception together while output and skid are both full
      do_reset(1);
      id_allowin = 1'b0; lat_lo = 0; lat_hi = 0;
      repeat (5) begin drive(); tick(); end
      br_taken = 1'b1; br_target = 32'h8000_2000;
      exc_flush = 1'b1; exc_target = 32'hbfc0_0380;
      drive();
      chk("both_pre_valid", 32'(if_valid), 32'd1);
      chk("both_pre_noreq", 32'(inst_sram_req), 32'd0);
      tick();
      br_taken = 1'b0; exc_flush = 1'b0; id_allowin = 1'b1;
      drive();
      chk("both_valid", 32'(if_valid), 32'd0);
      chk("both_req", 32'(inst_sram_req), 32'd1);
      chk("both_addr", inst_sram_addr, 32'hbfc0_0380);
      tick();
      drive(); chk("both_gap", 32'(if_valid), 32'd0); tick();
      drive();
      chk("both_out_valid", 32'(if_valid), 32'd1);
      chk("both_out_pc", if_pc, 32'hbfc0_0380);
      tick();

      // exception to a misaligned PC: one AdEL entry, then fetch idles
      do_reset(1);
      repeat (3) begin drive(); tick(); end
      exc_flush = 1'b1; exc_target = 32'h8000_0002;
      drive(); tick();
      exc_flush = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         drive();
         chk("adel_noreq", 32'(inst_sram_req), 32'd0);
         if (if_valid) begin
            got = 1'b1;
            chk("adel_out_pc", if_pc, 32'h8000_0002);
            chk("adel_out_inst", if_inst, 32'd0);
            chk("adel_out_flag", 32'(if_adel), 32'd1);
         end
         tick();
      end
      chk("adel_seen", 32'(got), 32'd1);
      repeat (5) begin
         drive();
         chk("adel_idle_req", 32'(inst_sram_req), 32'd0);
         chk("adel_idle_valid", 32'(if_valid), 32'd0);
         tick();
      end
      br_taken = 1'b1; br_target = 32'h8000_0100;
      drive(); tick();
      br_taken = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
         drive();
         if (inst_sram_req) begin
            got = 1'b1;
            chk("adel_resume_addr", inst_sram_addr, 32'h8000_0100);
         end
         tick();
      end
      chk("adel_resume_seen", 32'(got), 32'd1);

      // reset with output and skid both occupied
      do_reset(1);
      id_allowin = 1'b0;
      repeat (5) begin drive(); tick(); end
      reset = 1'b1;
      drive(); tick();
      reset = 1'b0; id_allowin = 1'b1;
      drive();
      chk("mid_valid", 32'(if_valid), 32'd0);
      chk("mid_req", 32'(inst_sram_req), 32'd1);
      chk("mid_addr", inst_sram_addr, RST_PC);
      tick();

      // random traffic against the reference stream model
      ok_pct = 70; lat_lo = 0; lat_hi = 3; n_hs = 0;
      for (int c = 0; c < 3000; c++) begin
         reset      = ($urandom_range(999) < 3);
         id_allowin = ($urandom_range(99) < 70);
         br_taken   = ($urandom_range(99) < 4);
         br_target  = 32'h8000_0000 | ($urandom & 32'h0000_fffc);
         exc_flush  = ($urandom_range(99) < 2);
         exc_target = ($urandom_range(9) == 0) ? (32'h8000_0002 | ($urandom & 32'h0000_0ff0))
                                                : 32'hbfc0_0380;
         drive();
         tick();
      end
      reset = 1'b0; br_taken = 1'b0; exc_flush = 1'b0;
      chk("liveness", 32'(n_hs >= 100), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
